// File: rtl/branch_target_predictor_if.sv
// branch_target_predictor_if: fetch lookup, resolved-branch update and stat bundle
//   master: drives if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict
//   slave : drives pred_taken, pred_target, stat_branches, stat_mispredicts
interface branch_target_predictor_if #(
   parameter int XLEN   = 64,
   parameter int STAT_W = 32
);
   logic [XLEN-1:0]   if_pc;
   logic              pred_taken;
   logic [XLEN-1:0]   pred_target;
   logic              upd_valid;
   logic [XLEN-1:0]   upd_pc;
   logic              upd_taken;
   logic [XLEN-1:0]   upd_target;
   logic              upd_mispredict;
   logic [STAT_W-1:0] stat_branches;
   logic [STAT_W-1:0] stat_mispredicts;
   modport master (
      output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
      input  pred_taken, pred_target, stat_branches, stat_mispredicts
   );
   modport slave (
      input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
      output pred_taken, pred_target, stat_branches, stat_mispredicts
   );
endinterface

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with saturating direction counters
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of branch_target_predictor_if
//           lookup  if_pc -> pred_taken / pred_target (zero latency)
//           update  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict
//           stats   stat_branches, stat_mispredicts (saturating)
module branch_target_predictor #(
   parameter int XLEN     = 64,
   parameter int ENTRIES  = 16,
   parameter int TAG_W    = 8,
   parameter int CTR_BITS = 2,
   parameter int STAT_W   = 32
) (
   input logic clk,
   input logic reset,
   branch_target_predictor_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
   logic                valid  [ENTRIES];
   logic [TAG_W-1:0]    tag_q  [ENTRIES];
   logic [XLEN-1:0]     target [ENTRIES];
   logic [CTR_BITS-1:0] ctr    [ENTRIES];
   logic [STAT_W-1:0]   stat_b, stat_m;
   logic [IDX_W-1:0]    l_idx, u_idx;
   logic [TAG_W-1:0]    l_tag, u_tag;
   logic                l_hit, u_hit, l_taken;
   logic [CTR_BITS-1:0] u_ctr;
   assign l_idx   = bus.if_pc[IDX_W+1:2];
   assign l_tag   = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign l_hit   = valid[l_idx] && (tag_q[l_idx] == l_tag);
   assign l_taken = l_hit && ctr[l_idx][CTR_BITS-1];
   // Lookup reads registered state only, so a same-cycle update is not bypassed.
   assign bus.pred_taken       = l_taken;
   assign bus.pred_target      = l_taken ? target[l_idx] : bus.if_pc + XLEN'(4);
   assign bus.stat_branches    = stat_b;
   assign bus.stat_mispredicts = stat_m;
   assign u_idx = bus.upd_pc[IDX_W+1:2];
   assign u_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign u_hit = valid[u_idx] && (tag_q[u_idx] == u_tag);
   assign u_ctr = ctr[u_idx];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            tag_q[i]  <= '0;
            target[i] <= '0;
            ctr[i]    <= CTR_WNT;
         end
         stat_b <= '0;
         stat_m <= '0;
      end else if (bus.upd_valid) begin
         stat_b <= stat_b + STAT_W'(!(&stat_b));
         stat_m <= stat_m + STAT_W'(bus.upd_mispredict && !(&stat_m));
         if (u_hit) begin
            ctr[u_idx] <= bus.upd_taken ? u_ctr + CTR_BITS'(!(&u_ctr)) : u_ctr - CTR_BITS'(|u_ctr);
            if (bus.upd_taken) target[u_idx] <= bus.upd_target;
         end else if (bus.upd_taken) begin
            // Allocation overwrites whatever entry aliases onto this index.
            valid[u_idx]  <= 1'b1;
            tag_q[u_idx]  <= u_tag;
            target[u_idx] <= bus.upd_target;
            ctr[u_idx]    <= CTR_WT;
         end
      end
   end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed self-checking bench for branch_target_predictor
module tb_branch_target_predictor;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   int exp_br = 0;
   int exp_mis = 0;
   always #5 clk = ~clk;
   branch_target_predictor_if #(.XLEN(64), .STAT_W(32)) b ();
   branch_target_predictor_if #(.XLEN(64), .STAT_W(4))  s ();
   branch_target_predictor #(.XLEN(64), .ENTRIES(16), .TAG_W(8), .CTR_BITS(2), .STAT_W(32))
      dut (.clk(clk), .reset(reset), .bus(b));
   branch_target_predictor #(.XLEN(64), .ENTRIES(16), .TAG_W(8), .CTR_BITS(2), .STAT_W(4))
      dut_s (.clk(clk), .reset(reset), .bus(s));

   // Called at a negedge; applies one update across the next posedge, returns at the following negedge.
   task automatic upd(input logic [63:0] pc, input logic tk, input logic [63:0] tgt, input logic mis);
      b.upd_valid = 1'b1; b.upd_pc = pc; b.upd_taken = tk; b.upd_target = tgt; b.upd_mispredict = mis;
      exp_br++;
      if (mis) exp_mis++;
      @(negedge clk);
      b.upd_valid = 1'b0;
   endtask

   task automatic look(input string name, input logic [63:0] pc, input logic etk, input logic [63:0] etgt);
      b.if_pc = pc;
      #1;
      checks++;
      if (b.pred_taken !== etk) begin
         errors++;
         $display("FAIL %s pred_taken got %0b expected %0b", name, b.pred_taken, etk);
      end
      checks++;
      if (b.pred_target !== etgt) begin
         errors++;
         $display("FAIL %s pred_target got %h expected %h", name, b.pred_target, etgt);
      end
   endtask

   task automatic stats(input string name);
      checks++;
      if (b.stat_branches !== 32'(exp_br)) begin
         errors++;
         $display("FAIL %s stat_branches got %0d expected %0d", name, b.stat_branches, exp_br);
      end
      checks++;
      if (b.stat_mispredicts !== 32'(exp_mis)) begin
         errors++;
         $display("FAIL %s stat_mispredicts got %0d expected %0d", name, b.stat_mispredicts, exp_mis);
      end
   endtask

   task automatic test_reset();
      b.upd_valid = 1'b0; b.upd_pc = '0; b.upd_taken = 1'b0; b.upd_target = '0; b.upd_mispredict = 1'b0;
      s.upd_valid = 1'b0; s.upd_pc = '0; s.upd_taken = 1'b0; s.upd_target = '0; s.upd_mispredict = 1'b0;
      b.if_pc = 64'h100; s.if_pc = 64'h100;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      look("reset", 64'h100, 1'b0, 64'h104);
      stats("reset");
   endtask

   task automatic test_allocate();
      upd(64'h100, 1'b1, 64'h80, 1'b0);
      look("alloc", 64'h100, 1'b1, 64'h80);
      stats("alloc");
   endtask

   task automatic test_counter();
      upd(64'h100, 1'b0, 64'h0, 1'b1);
      look("ctr_10_01", 64'h100, 1'b0, 64'h104);
      upd(64'h100, 1'b1, 64'h88, 1'b1);
      look("ctr_01_10_newtgt", 64'h100, 1'b1, 64'h88);
   endtask

   task automatic test_saturation();
      repeat (4) upd(64'h100, 1'b1, 64'h88, 1'b0);
      look("sat_11", 64'h100, 1'b1, 64'h88);
      upd(64'h100, 1'b0, 64'h0, 1'b0);
      look("sat_11_10", 64'h100, 1'b1, 64'h88);
      upd(64'h100, 1'b0, 64'h0, 1'b0);
      look("sat_10_01", 64'h100, 1'b0, 64'h104);
      repeat (3) upd(64'h100, 1'b0, 64'h0, 1'b0);
      upd(64'h100, 1'b1, 64'h90, 1'b0);
      look("sat_00_01", 64'h100, 1'b0, 64'h104);
      upd(64'h100, 1'b1, 64'h94, 1'b0);
      look("sat_01_10", 64'h100, 1'b1, 64'h94);
      stats("sat");
   endtask

   task automatic test_alias();
      upd(64'h140, 1'b1, 64'h200, 1'b0);
      look("alias_old", 64'h100, 1'b0, 64'h104);
      look("alias_new", 64'h140, 1'b1, 64'h200);
      upd(64'h180, 1'b0, 64'h300, 1'b0);
      look("miss_nt_nochange", 64'h140, 1'b1, 64'h200);
      b.upd_pc = 64'h140; b.upd_taken = 1'b1; b.upd_target = 64'hdead; b.upd_mispredict = 1'b1;
      @(negedge clk);
      look("idle_ignored", 64'h140, 1'b1, 64'h200);
      stats("idle");
   endtask

   task automatic test_back_to_back();
      b.if_pc = 64'h140;
      b.upd_valid = 1'b1; b.upd_pc = 64'h140; b.upd_taken = 1'b1; b.upd_target = 64'h240; b.upd_mispredict = 1'b0;
      exp_br++;
      look("no_bypass", 64'h140, 1'b1, 64'h200);
      @(negedge clk);
      b.upd_taken = 1'b0;
      exp_br++;
      look("b2b_first", 64'h140, 1'b1, 64'h240);
      @(negedge clk);
      b.upd_valid = 1'b0;
      look("b2b_second", 64'h140, 1'b1, 64'h240);
      stats("b2b");
   endtask

   task automatic test_reset_mid();
      repeat (3) upd(64'h140, 1'b1, 64'h240, 1'b1);
      stats("pre_reset");
      look("pre_reset", 64'h140, 1'b1, 64'h240);
      @(posedge clk);
      #2 reset = 1'b1;
      exp_br = 0; exp_mis = 0;
      #1;
      look("async_reset", 64'h140, 1'b0, 64'h144);
      stats("async_reset");
      @(negedge clk);
      b.upd_valid = 1'b1; b.upd_pc = 64'h140; b.upd_taken = 1'b1; b.upd_target = 64'h500; b.upd_mispredict = 1'b1;
      @(negedge clk);
      b.upd_valid = 1'b0;
      reset = 1'b0;
      look("upd_during_reset", 64'h140, 1'b0, 64'h144);
      stats("upd_during_reset");
   endtask

   task automatic test_stat_saturate();
      s.upd_valid = 1'b1; s.upd_pc = 64'h100; s.upd_taken = 1'b1; s.upd_target = 64'h80; s.upd_mispredict = 1'b1;
      repeat (15) @(negedge clk);
      checks++;
      if (s.stat_branches !== 4'hf) begin
         errors++;
         $display("FAIL stat_reach_f branches got %h expected f", s.stat_branches);
      end
      repeat (3) @(negedge clk);
      s.upd_valid = 1'b0;
      checks++;
      if (s.stat_branches !== 4'hf) begin
         errors++;
         $display("FAIL stat_hold branches got %h expected f", s.stat_branches);
      end
      checks++;
      if (s.stat_mispredicts !== 4'hf) begin
         errors++;
         $display("FAIL stat_hold mispredicts got %h expected f", s.stat_mispredicts);
      end
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_counter();
      test_saturation();
      test_alias();
      test_back_to_back();
      test_reset_mid();
      test_stat_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
